// File: rtl/seq_det_pkg.sv
// Shared constants for the programmable serial pattern detector:
// default widths and the one-hot controller state encoding.
package seq_det_pkg;

   localparam int PAT_W_DEF = 8;
   localparam int LEN_W_DEF = 4;
   localparam int CNT_W_DEF = 8;

   localparam int ST_W = 3;
   localparam logic [ST_W-1:0] ST_IDLE = 3'b001;
   localparam logic [ST_W-1:0] ST_RUN  = 3'b010;
   localparam logic [ST_W-1:0] ST_DONE = 3'b100;

endpackage

// File: rtl/seq_match_core.sv
// Serial matcher: shifts valid bits into a history register, tracks how many
// usable bits it holds, and flags a match on the bit being sampled.
module seq_match_core #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             valid,
   input  logic             data_in,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic             overlap,
   output logic             match
);

   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] hist_next;
   logic [PAT_W-1:0] mask;
   logic [LEN_W-1:0] fill;
   logic [LEN_W-1:0] fill_next;

   always_comb begin
      mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (i < int'(len));
      end
      hist_next = {hist[PAT_W-2:0], data_in};
      fill_next = (fill >= len) ? len : fill + LEN_W'(1);
      match     = valid && (fill_next == len) &&
                  ((hist_next & mask) == (pattern & mask));
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= '0;
         fill <= '0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
      end else if (valid) begin
         hist <= hist_next;
         // Non-overlapping mode must collect a whole fresh pattern after a hit.
         fill <= (match && !overlap) ? '0 : fill_next;
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// Pattern-detection controller: config registers, IDLE/RUN/DONE sequencing,
// match counting and the registered status pulses around seq_match_core.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic             start,
   input  logic             abort,
   input  logic             valid,
   input  logic             data_in,
   output logic             busy,
   output logic             pat_dec,
   output logic             done,
   output logic             cfg_err,
   output logic [CNT_W-1:0] match_cnt
);

   logic [ST_W-1:0]  state;
   logic [PAT_W-1:0] pattern_r;
   logic [LEN_W-1:0] len_r;
   logic             overlap_r;
   logic [CNT_W-1:0] target_r;

   logic in_idle;
   logic in_run;
   logic cfg_ok;
   logic accept;
   logic match;
   logic hit;
   logic reached;

   assign in_idle = (state == ST_IDLE);
   assign in_run  = (state == ST_RUN);
   assign busy    = in_run;
   assign done    = (state == ST_DONE);

   assign cfg_ok  = (len_r != '0) && (len_r <= LEN_W'(PAT_W)) && (target_r != '0);
   assign accept  = in_idle && start && cfg_ok;
   assign hit     = in_run && match && !abort;
   assign reached = hit && ((match_cnt + CNT_W'(1)) == target_r);

   seq_match_core #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .valid   (in_run && valid),
      .data_in (data_in),
      .pattern (pattern_r),
      .len     (len_r),
      .overlap (overlap_r),
      .match   (match)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pattern_r <= '0;
         len_r     <= '0;
         overlap_r <= 1'b0;
         target_r  <= '0;
         match_cnt <= '0;
         pat_dec   <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         pat_dec <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               // An accepted start runs on the old config, so a coincident write is dropped.
               if (cfg_we && !accept) begin
                  pattern_r <= cfg_pattern;
                  len_r     <= cfg_len;
                  overlap_r <= cfg_overlap;
                  target_r  <= cfg_target;
               end
               if (start) begin
                  if (cfg_ok) begin
                     state     <= ST_RUN;
                     match_cnt <= '0;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (hit) begin
                  pat_dec   <= 1'b1;
                  match_cnt <= match_cnt + CNT_W'(1);
                  if (reached) state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: a queue-based model of the detection
// rules checked every cycle, plus directed streams with literal expectations.
module tb_seq_det_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_we = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic       cfg_overlap = 1'b0;
   logic [7:0] cfg_target = '0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       valid = 1'b0;
   logic       data_in = 1'b0;
   logic       busy;
   logic       pat_dec;
   logic       done;
   logic       cfg_err;
   logic [7:0] match_cnt;

   int n_checks = 0;
   int n_err    = 0;

   seq_det_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_target  (cfg_target),
      .start       (start),
      .abort       (abort),
      .valid       (valid),
      .data_in     (data_in),
      .busy        (busy),
      .pat_dec     (pat_dec),
      .done        (done),
      .cfg_err     (cfg_err),
      .match_cnt   (match_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the last len received bits are kept in a queue, oldest first.
   logic [7:0] m_pat = '0;
   int         m_len = 0;
   bit         m_ovl = 1'b0;
   int         m_tgt = 0;
   bit         q[$];
   bit         e_busy = 0, e_done = 0, e_dec = 0, e_err = 0;
   int         e_cnt = 0;

   function automatic bit model_hit();
      if (q.size() != m_len) return 1'b0;
      for (int i = 0; i < m_len; i++)
         if (q[i] != m_pat[m_len-1-i]) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pat = '0; m_len = 0; m_ovl = 0; m_tgt = 0; q.delete();
         e_busy = 0; e_done = 0; e_dec = 0; e_err = 0; e_cnt = 0;
      end else begin
         e_dec = 0;
         e_err = 0;
         if (e_done) begin
            e_done = 0;
         end else if (e_busy) begin
            if (abort) begin
               e_busy = 0;
            end else if (valid) begin
               q.push_back(data_in);
               if (q.size() > m_len) void'(q.pop_front());
               if (model_hit()) begin
                  e_dec = 1;
                  e_cnt++;
                  if (!m_ovl) q.delete();
                  if (e_cnt == m_tgt) begin
                     e_busy = 0;
                     e_done = 1;
                  end
               end
            end
         end else begin
            automatic bit legal = (m_len >= 1) && (m_len <= 8) && (m_tgt != 0);
            if (start) begin
               if (legal) begin
                  e_busy = 1; e_cnt = 0; q.delete();
               end else begin
                  e_err = 1;
               end
            end
            if (cfg_we && !(start && legal)) begin
               m_pat = cfg_pattern; m_len = int'(cfg_len);
               m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("busy", 32'(busy), 32'(e_busy));
         check("done", 32'(done), 32'(e_done));
         check("pat_dec", 32'(pat_dec), 32'(e_dec));
         check("cfg_err", 32'(cfg_err), 32'(e_err));
         check("match_cnt", 32'(match_cnt), 32'(e_cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
      cfg_we = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
      tick();
      cfg_we = 0;
   endtask

   task automatic do_start();
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic do_abort();
      abort = 1;
      tick();
      abort = 0;
   endtask

   // Sends n bits MSB first; exp holds the pat_dec expected right after each bit's edge.
   task automatic send(input string name, input logic [15:0] bits, input int n,
                       input logic [15:0] exp, input int gap);
      for (int i = 0; i < n; i++) begin
         valid = 1; data_in = bits[n-1-i];
         tick();
         valid = 0; data_in = 0;
         check(name, 32'(pat_dec), 32'(exp[n-1-i]));
         for (int g = 0; g < gap; g++) begin
            tick();
            check({name, "_gap"}, 32'(pat_dec), 32'd0);
         end
      end
   endtask

   initial begin
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_cnt", 32'(match_cnt), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 0;
      tick();

      configure(8'b1011, 4'd4, 1'b0, 8'd5);
      do_start();
      check("s1_busy_start", 32'(busy), 32'd1);
      send("s1_dec", 16'b1011011, 7, 16'b0001000, 0);
      check("s1_cnt", 32'(match_cnt), 32'd1);
      check("s1_busy", 32'(busy), 32'd1);
      do_abort();
      check("s1_abort_idle", 32'(busy), 32'd0);

      configure(8'b1011, 4'd4, 1'b1, 8'd5);
      do_start();
      check("s2_cnt_cleared", 32'(match_cnt), 32'd0);
      send("s2_dec", 16'b1011011, 7, 16'b0001001, 0);
      check("s2_cnt", 32'(match_cnt), 32'd2);
      do_abort();

      configure(8'b1011, 4'd4, 1'b1, 8'd2);
      do_start();
      send("s3_dec", 16'b1011011, 7, 16'b0001001, 0);
      check("s3_done", 32'(done), 32'd1);
      check("s3_busy", 32'(busy), 32'd0);
      send("s3_after", 16'b1011, 4, 16'b0000, 0);
      check("s3_cnt_hold", 32'(match_cnt), 32'd2);
      check("s3_done_gone", 32'(done), 32'd0);

      configure(8'b1011, 4'd4, 1'b0, 8'd5);
      do_start();
      send("s4_dec", 16'b1011, 4, 16'b0001, 2);
      check("s4_cnt", 32'(match_cnt), 32'd1);
      do_abort();

      configure(8'b1011, 4'd0, 1'b0, 8'd3);
      start = 1;
      tick();
      start = 0;
      check("s5_len0_err", 32'(cfg_err), 32'd1);
      check("s5_len0_busy", 32'(busy), 32'd0);
      tick();
      check("s5_err_pulse", 32'(cfg_err), 32'd0);
      configure(8'b1011, 4'd4, 1'b0, 8'd0);
      do_start();
      check("s5_tgt0_err", 32'(cfg_err), 32'd1);
      configure(8'b1011, 4'd9, 1'b0, 8'd3);
      do_start();
      check("s5_len9_err", 32'(cfg_err), 32'd1);
      check("s5_len9_busy", 32'(busy), 32'd0);

      configure(8'b1011, 4'd4, 1'b0, 8'd5);
      do_start();
      cfg_we = 1; cfg_pattern = 8'b0000; cfg_len = 4'd2; cfg_target = 8'd1;
      tick();
      cfg_we = 0;
      send("s5_run_we", 16'b1011, 4, 16'b0001, 0);
      check("s5_run_we_busy", 32'(busy), 32'd1);
      do_abort();

      do_start();
      send("s6_pre", 16'b101, 3, 16'b000, 0);
      valid = 1; data_in = 1; abort = 1;
      tick();
      valid = 0; data_in = 0; abort = 0;
      check("s6_dec", 32'(pat_dec), 32'd0);
      check("s6_cnt", 32'(match_cnt), 32'd0);
      check("s6_idle", 32'(busy), 32'd0);
      check("s6_done", 32'(done), 32'd0);

      configure(8'h01, 4'd1, 1'b1, 8'd3);
      do_start();
      send("s7_len1", 16'b1101, 4, 16'b1101, 0);
      check("s7_done", 32'(done), 32'd1);
      check("s7_cnt", 32'(match_cnt), 32'd3);
      tick();

      configure(8'hA5, 4'd8, 1'b0, 8'd1);
      do_start();
      send("s8_len8", 16'b10100101, 8, 16'b00000001, 0);
      check("s8_done", 32'(done), 32'd1);
      tick();

      configure(8'b1011, 4'd4, 1'b0, 8'd5);
      do_start();
      send("s9_dec", 16'b1011, 4, 16'b0001, 0);
      #2 rst = 1;
      #1;
      check("s9_rst_busy", 32'(busy), 32'd0);
      check("s9_rst_dec", 32'(pat_dec), 32'd0);
      check("s9_rst_cnt", 32'(match_cnt), 32'd0);
      check("s9_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 0;
      tick();
      do_start();
      check("s9_cfg_cleared_err", 32'(cfg_err), 32'd1);
      check("s9_cfg_cleared_busy", 32'(busy), 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
